// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// The master modport is the arbiter's view; slave is the core-plus-memory view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_width;
    logic        d_usignext;
    logic [31:0] d_rdata;
    logic        d_valid;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_width;
    logic        m_usignext;
    logic [31:0] m_rdata;
    logic        m_ack;

    logic        pause;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_width, d_usignext,
               m_rdata, m_ack,
        output if_rdata, if_valid, d_rdata, d_valid,
               m_req, m_we, m_addr, m_wdata, m_width, m_usignext, pause
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_width, d_usignext,
               m_rdata, m_ack,
        input  if_rdata, if_valid, d_rdata, d_valid,
               m_req, m_we, m_addr, m_wdata, m_width, m_usignext, pause
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// at a time. Data wins by default; a starvation counter forces a fetch through.
// Handshake: a requester holds x_req and its fields until x_valid; a request still high
// in the x_valid cycle is taken as the next request. m_req is held until m_ack.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_D = 2'd1, BUSY_I = 2'd2} state_t;

    state_t        state, state_n;
    logic [CW-1:0] starve_cnt, starve_n;
    logic          m_we_n, m_usignext_n, if_valid_n, d_valid_n, force_fetch;
    logic [31:0]   m_addr_n, m_wdata_n, if_rdata_n, d_rdata_n;
    logic [1:0]    m_width_n;

    always_comb begin
        state_n      = state;
        starve_n     = starve_cnt;
        m_we_n       = bus.m_we;
        m_addr_n     = bus.m_addr;
        m_wdata_n    = bus.m_wdata;
        m_width_n    = bus.m_width;
        m_usignext_n = bus.m_usignext;
        if_rdata_n   = bus.if_rdata;
        d_rdata_n    = bus.d_rdata;
        if_valid_n   = 1'b0;
        d_valid_n    = 1'b0;
        force_fetch  = bus.if_req && (starve_cnt == LIMIT_C);
        unique case (state)
            IDLE: begin
                if (!bus.if_req) starve_n = '0;
                if (bus.d_req && !force_fetch) begin
                    state_n      = BUSY_D;
                    m_we_n       = bus.d_we;
                    m_addr_n     = bus.d_addr;
                    m_wdata_n    = bus.d_wdata;
                    m_width_n    = bus.d_width;
                    m_usignext_n = bus.d_usignext;
                    if (bus.if_req && starve_cnt != LIMIT_C) starve_n = starve_cnt + CW'(1);
                end else if (bus.if_req) begin
                    state_n      = BUSY_I;
                    m_we_n       = 1'b0;
                    m_addr_n     = bus.if_addr;
                    m_wdata_n    = '0;
                    m_width_n    = 2'b10;
                    m_usignext_n = 1'b0;
                    starve_n     = '0;
                end
            end
            BUSY_D: begin
                if (bus.m_ack) begin
                    d_valid_n = 1'b1;
                    // Stores leave the last load result visible.
                    if (!bus.m_we) d_rdata_n = bus.m_rdata;
                    state_n = IDLE;
                end
            end
            BUSY_I: begin
                if (bus.m_ack) begin
                    if_valid_n = 1'b1;
                    if_rdata_n = bus.m_rdata;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            bus.m_req      <= 1'b0;
            bus.m_we       <= 1'b0;
            bus.m_addr     <= '0;
            bus.m_wdata    <= '0;
            bus.m_width    <= '0;
            bus.m_usignext <= 1'b0;
            bus.if_valid   <= 1'b0;
            bus.if_rdata   <= '0;
            bus.d_valid    <= 1'b0;
            bus.d_rdata    <= '0;
        end else begin
            state          <= state_n;
            starve_cnt     <= starve_n;
            bus.m_req      <= (state_n != IDLE);
            bus.m_we       <= m_we_n;
            bus.m_addr     <= m_addr_n;
            bus.m_wdata    <= m_wdata_n;
            bus.m_width    <= m_width_n;
            bus.m_usignext <= m_usignext_n;
            bus.if_valid   <= if_valid_n;
            bus.if_rdata   <= if_rdata_n;
            bus.d_valid    <= d_valid_n;
            bus.d_rdata    <= d_rdata_n;
        end
    end

    assign bus.pause = (bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid);
    assign state_dbg = state;
endmodule
